// File: rtl/seq_detect_param.sv
// Serial pattern detector: shifts DIN into a history register on enabled edges and
// pulses MATCH when the last PAT_W sampled bits equal PATTERN; counts matches with saturation.
module seq_detect_param #(
  parameter int                 PAT_W   = 3,
  parameter logic [PAT_W-1:0]   PATTERN = 3'b100,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIN,
  input  logic             CLR_CNT,
  output logic             MATCH,
  output logic [CNT_W-1:0] MATCH_CNT
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_up;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    fill_up = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    if (EN) begin
      hist_d  = {hist_q[PAT_W-2:0], DIN};
      fill_up = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
      // The fill gate keeps reset-value history from matching patterns such as all-zeros.
      match_d = (fill_up == FILL_MAX) && (hist_d == PATTERN);
      fill_d  = (match_d && (OVERLAP == 0)) ? '0 : fill_up;
    end

    if (CLR_CNT) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MATCH     = match_q;
  assign MATCH_CNT = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param; several parameterisations share one stimulus bus.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       clr_cnt;

  logic       m_def, m_ov1, m_ov0, m_z, m_sat;
  logic [7:0] c_def, c_ov1, c_ov0, c_z;
  logic [1:0] c_sat;

  int n_checks = 0;
  int n_pass   = 0;

  seq_detect_param u_def (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr_cnt),
    .MATCH(m_def), .MATCH_CNT(c_def)
  );

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) u_ov1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr_cnt),
    .MATCH(m_ov1), .MATCH_CNT(c_ov1)
  );

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) u_ov0 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr_cnt),
    .MATCH(m_ov0), .MATCH_CNT(c_ov0)
  );

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b000), .OVERLAP(1), .CNT_W(8)) u_z (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr_cnt),
    .MATCH(m_z), .MATCH_CNT(c_z)
  );

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b100), .OVERLAP(1), .CNT_W(2)) u_sat (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr_cnt),
    .MATCH(m_sat), .MATCH_CNT(c_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Present one bit with EN=1 for a single edge; outputs are stable 1ns after that edge.
  task automatic send(input logic b, input logic clr = 1'b0);
    en      = 1'b1;
    din     = b;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    en      = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic idle_cycle();
    en  = 1'b0;
    din = ~din;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] ov_stream;
    logic [4:0] ov1_exp;
    logic [4:0] ov0_exp;

    en = 1'b0; din = 1'b0; clr_cnt = 1'b0; rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_match", m_def, 0);
    check("reset_cnt", c_def, 0);

    // Defaults: 1,0,0 completes the pattern on the third edge.
    send(1'b1); check("def_b1", m_def, 0);
    send(1'b0); check("def_b2", m_def, 0);
    send(1'b0); check("def_b3_match", m_def, 1);
    check("def_cnt", c_def, 1);
    idle_cycle(); check("def_pulse_one_cycle", m_def, 0);
    check("def_cnt_hold", c_def, 1);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    send(1'b1); send(1'b0); send(1'b0);
    check("pre_reset_match", m_def, 1);
    rst_n = 1'b0;
    #2;
    check("async_rst_match", m_def, 0);
    check("async_rst_cnt", c_def, 0);
    rst_n = 1'b1;

    // Overlap vs non-overlap on pattern 101 with stream 1,0,1,0,1.
    do_reset();
    ov_stream = 5'b10101;
    ov1_exp   = 5'b00101;
    ov0_exp   = 5'b00100;
    for (int i = 4; i >= 0; i--) begin
      send(ov_stream[i]);
      check($sformatf("ov1_bit%0d", 5 - i), m_ov1, ov1_exp[i]);
      check($sformatf("ov0_bit%0d", 5 - i), m_ov0, ov0_exp[i]);
    end
    check("ov1_cnt", c_ov1, 2);
    check("ov0_cnt", c_ov0, 1);

    // Enable gaps: DIN toggles while EN=0 and must be ignored.
    do_reset();
    send(1'b1);
    idle_cycle(); check("gap_idle1", m_def, 0);
    idle_cycle(); check("gap_idle2", m_def, 0);
    send(1'b0); check("gap_b2", m_def, 0);
    send(1'b0); check("gap_b3_match", m_def, 1);
    check("gap_cnt", c_def, 1);

    // Fill gate: all-zero pattern needs three sampled zeros after reset.
    do_reset();
    send(1'b0); check("zero_b1", m_z, 0);
    send(1'b0); check("zero_b2", m_z, 0);
    send(1'b0); check("zero_b3_match", m_z, 1);
    send(1'b0); check("zero_b4_overlap", m_z, 1);
    check("zero_cnt", c_z, 2);

    // Partial sequence before reset is discarded.
    do_reset();
    send(1'b1); send(1'b0);
    do_reset();
    send(1'b0); check("midrst_match", m_def, 0);
    check("midrst_cnt", c_def, 0);

    // Saturation with a 2-bit counter, then clear coincident with a match.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(1'b1); send(1'b0); send(1'b0);
      check($sformatf("sat_match%0d", k), m_sat, 1);
      check($sformatf("sat_cnt%0d", k), c_sat, (k > 3) ? 3 : k);
    end
    send(1'b1); send(1'b0);
    send(1'b0, 1'b1);
    check("clr_match_kept", m_sat, 1);
    check("clr_cnt_zero", c_sat, 0);
    send(1'b1, 1'b1);
    check("clr_no_match", m_sat, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 3, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 3'b100, giving the target bit sequence, MSB received first (width PAT_W).
REQ-003 The block SHALL have parameter OVERLAP, default 1; 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-005 The block SHALL have port CLK  input  1  sole clock, rising-edge active.
REQ-006 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port EN  input  1  sample enable; DIN is consumed only on edges where EN=1.
REQ-008 The block SHALL have port DIN  input  1  serial data bit.
REQ-009 The block SHALL have port CLR_CNT  input  1  synchronous clear of MATCH_CNT.
REQ-010 The block SHALL have port MATCH  output  1  registered one-cycle pulse on pattern completion.
REQ-011 The block SHALL have port MATCH_CNT  output  CNT_W  saturating count of matches.
REQ-012 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RST_N.

Function
REQ-013 The block SHALL hold a PAT_W-bit history register HIST and a fill counter FILL (range 0..PAT_W) as its state.
REQ-014 On each edge with EN=1, the block SHALL update HIST to {HIST[PAT_W-2:0], DIN} and FILL to min(FILL+1, PAT_W).
REQ-015 On each edge with EN=1, the block SHALL set MATCH to 1 iff the updated FILL equals PAT_W and the updated HIST equals PATTERN; otherwise MATCH SHALL be 0.
REQ-016 MATCH latency SHALL be zero cycles beyond the sampling edge: MATCH is high in the cycle immediately following the edge that samples the final pattern bit.
REQ-017 MATCH SHALL never be high for more than one consecutive cycle unless consecutive EN edges each complete a match (overlap mode only).
REQ-018 On each edge with EN=0, the block SHALL hold HIST and FILL, and SHALL set MATCH to 0.
REQ-019 When OVERLAP=1 and a match occurs, FILL SHALL remain at PAT_W, so the trailing bits may begin the next match.
REQ-020 When OVERLAP=0 and a match occurs, FILL SHALL be set to 0 on that same edge; HIST is don't-care until refilled.
REQ-021 The FILL gate SHALL prevent false matches from reset-value history (e.g. PATTERN=000 requires PAT_W sampled zeros).
REQ-022 On each edge where MATCH is being set to 1, the block SHALL increment MATCH_CNT by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-023 When CLR_CNT=1, MATCH_CNT SHALL become 0 on that edge; CLR_CNT SHALL take priority over a coincident increment.
REQ-024 CLR_CNT SHALL NOT affect HIST, FILL or MATCH.

Reset
REQ-025 While RST_N=0, the block SHALL immediately force HIST=0, FILL=0, MATCH=0 and MATCH_CNT=0, independent of CLK.
REQ-026 After RST_N deasserts, the first EN edge SHALL be treated as the first received bit; any partial sequence present before reset SHALL be discarded.

Verification
REQ-027 Reset: assert RST_N=0 mid-cycle -> MATCH=0 and MATCH_CNT=0 before the next CLK edge.
REQ-028 Defaults: feed DIN=1,0,0 with EN=1 -> MATCH=1 for exactly one cycle after the third edge; MATCH_CNT=1.
REQ-029 Overlap: PATTERN=3'b101, stream 1,0,1,0,1 -> OVERLAP=1 gives matches after bits 3 and 5 (MATCH_CNT=2); OVERLAP=0 gives one match after bit 3 (MATCH_CNT=1).
REQ-030 Enable gaps: send 1, hold EN=0 for 2 cycles with DIN toggling, then send 0,0 -> one match; MATCH=0 throughout the EN=0 cycles.
REQ-031 Fill gate and mid-sequence reset: PATTERN=3'b000 -> no match until the third 0 after reset; with defaults, send 1,0, pulse RST_N low, then send 0 -> no match.
REQ-032 Saturation/clear: CNT_W=2 with 5 matches -> MATCH_CNT=3; CLR_CNT=1 on a match edge -> MATCH_CNT=0 and MATCH=1.
